gcm_aes_sequencer: RTL and testbench
====================================

GCM_AES_SEQUENCER -- requirements
Module: gcm_aes_sequencer

Interface
REQ-001 SHALL have parameter INIT_WAIT, default 44: idle cycles after i_new_instance deasserts before the first AAD block (hash subkey H generation).
REQ-002 SHALL have parameter INIT_HOLD, default 2: cycles core i_new_instance is held high.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only under GCM_SEQ_TIMEOUT_EN.
REQ-004 SHALL have ports, one clock; reset is asynchronous and active-high:
  clk  in  1  clock
  rst  in  1  async active-high reset
  i_start  in  1  begin a message (sampled in IDLE only)
  i_cipher_key  in  128  key, latched on start
  i_iv  in  96  IV, latched on start
  i_aad_size  in  64  AAD length in bits, latched
  i_plain_text_size  in  64  plaintext length in bits, latched
  i_aad_valid / o_aad_ready / i_aad_block  in/out/in  1/1/128  AAD stream
  i_pt_valid / o_pt_ready / i_pt_block  in/out/in  1/1/128  plaintext stream
  o_ct_valid / o_ct_block  out  1/128  ciphertext, one-cycle pulse per block
  o_tag_valid / o_tag  out  1/128  tag, one-cycle pulse
  o_busy  out  1  high outside IDLE
  o_error  out  1  one-cycle timeout pulse
  o_core_new_instance / o_core_pt_instance  out  1/1  to gcm_aes
  o_core_cipher_key / o_core_iv / o_core_aad / o_core_plain_text  out  128/96/128/128  to gcm_aes
  o_core_aad_size / o_core_plain_text_size  out  64/64  to gcm_aes
  i_core_cipher_text / i_core_tag  in  128/128  from gcm_aes
  i_core_cp_ready / i_core_tag_ready  in  1/1  from gcm_aes

Function
REQ-005 SHALL implement FSM IDLE -> INIT -> HWAIT -> AAD -> PT_FEED <-> CT_WAIT -> TAG_WAIT -> IDLE.
REQ-006 SHALL, in IDLE with i_start=1, latch key/IV/sizes and drive them on o_core_* until the next start.
REQ-007 SHALL hold o_core_new_instance=1 for exactly INIT_HOLD cycles in INIT, then count INIT_WAIT cycles in HWAIT.
REQ-008 SHALL compute block counts as ceil(size/128) in 57-bit counters; a partial last block is passed unmodified.
REQ-009 SHALL assert o_aad_ready in AAD; on valid&&ready, register i_aad_block onto o_core_aad (held until next accept) and decrement the AAD count; at most one block per cycle.
REQ-010 SHALL, in PT_FEED, assert o_pt_ready; on accept, drive o_core_plain_text and pulse o_core_pt_instance for one cycle, then enter CT_WAIT with o_pt_ready=0.
REQ-011 SHALL, in CT_WAIT on i_core_cp_ready=1, pulse o_ct_valid the next cycle with o_ct_block=i_core_cipher_text (registered), then return to PT_FEED or, after the last block, go to TAG_WAIT.
REQ-012 SHALL, in TAG_WAIT on i_core_tag_ready=1, pulse o_tag_valid one cycle with the registered tag and return to IDLE.
REQ-013 SHALL skip AAD when AAD count is 0 and skip PT_FEED/CT_WAIT when PT count is 0 (tag-only message).
REQ-014 SHALL ignore i_start while o_busy=1; SHALL ignore i_*_valid outside its own phase.
REQ-015 SHALL ignore i_core_cp_ready/i_core_tag_ready outside CT_WAIT/TAG_WAIT.

Reset
REQ-016 SHALL on rst force IDLE, clear counters and drive all outputs to 0, including mid-message; no partial ct/tag pulse after reset release.

Configuration
REQ-017 SHALL, with GCM_SEQ_TIMEOUT_EN defined, count cycles in CT_WAIT/TAG_WAIT; on reaching TIMEOUT_CYCLES pulse o_error for one cycle and go to IDLE.
REQ-018 SHALL, without GCM_SEQ_TIMEOUT_EN, wait indefinitely; o_error tied 0.

Structure
REQ-019 SHALL place state enum and BLOCK_W=128, IV_W=96, SIZE_W=64, CNT_W=57 in package gcm_seq_pkg.
REQ-020 SHALL place the timeout counter in sub-module gcm_seq_watchdog, instantiated only under GCM_SEQ_TIMEOUT_EN.

Verification
REQ-021 Key=0, IV=0, sizes 0/0 -> no stream handshakes, o_tag_valid with 58e2fccefa7e3061367f1d57a4e7455a.
REQ-022 Key=0, IV=0, PT=128'h0, AAD size 0 -> o_ct_block 0388dace60b6a392f328c2b971b2fe78, tag ab6e47d42cec13bdf53a67b21257bddf.
REQ-023 AAD size 128, PT size 512, i_pt_valid toggled every other cycle -> exactly 4 ct pulses, 1 AAD accept, o_core_pt_instance never high in CT_WAIT.
REQ-024 i_start pulsed while busy -> latched key/IV unchanged, output sequence identical to unperturbed run.
REQ-025 rst asserted in CT_WAIT -> next cycle o_busy=0, all outputs 0; new message afterwards completes correctly.
REQ-026 With GCM_SEQ_TIMEOUT_EN, i_core_tag_ready held 0 -> o_error pulse 1024 cycles after TAG_WAIT entry, FSM in IDLE.

Source files
------------

// File: rtl/gcm_seq_pkg.sv
// Shared widths, FSM state type and block-count helper for the GCM-AES sequencer.
package gcm_seq_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IV_W    = 96;
  localparam int unsigned SIZE_W  = 64;
  localparam int unsigned CNT_W   = 57;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_HWAIT    = 3'd2,
    S_AAD      = 3'd3,
    S_PT_FEED  = 3'd4,
    S_CT_WAIT  = 3'd5,
    S_TAG_WAIT = 3'd6
  } seq_state_t;

  // ceil(bits/128): whole blocks plus one for any partial tail
  function automatic logic [CNT_W-1:0] blocks_of(input logic [SIZE_W-1:0] bits);
    return bits[SIZE_W-1:7] + {{(CNT_W-1){1'b0}}, |bits[6:0]};
  endfunction

endpackage

// File: rtl/gcm_seq_watchdog.sv
// Cycle watchdog for the core-response wait states; only built with GCM_SEQ_TIMEOUT_EN.
module gcm_seq_watchdog
  import gcm_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  assign o_expired = i_en && !i_restart && (r_cnt == W'(TIMEOUT_CYCLES - 1));

  // count consecutive cycles spent waiting; restart on every leave/accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_restart || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gcm_aes_sequencer.sv
// Message sequencer in front of a gcm_aes core: init, H wait, AAD and PT streaming,
// ciphertext/tag return. Optional watchdog enabled by macro GCM_SEQ_TIMEOUT_EN.
module gcm_aes_sequencer
  import gcm_seq_pkg::*;
#(
  parameter int unsigned INIT_WAIT      = 44,
  parameter int unsigned INIT_HOLD      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [BLOCK_W-1:0] i_cipher_key,
  input  logic [IV_W-1:0]    i_iv,
  input  logic [SIZE_W-1:0]  i_aad_size,
  input  logic [SIZE_W-1:0]  i_plain_text_size,
  input  logic               i_aad_valid,
  output logic               o_aad_ready,
  input  logic [BLOCK_W-1:0] i_aad_block,
  input  logic               i_pt_valid,
  output logic               o_pt_ready,
  input  logic [BLOCK_W-1:0] i_pt_block,
  output logic               o_ct_valid,
  output logic [BLOCK_W-1:0] o_ct_block,
  output logic               o_tag_valid,
  output logic [BLOCK_W-1:0] o_tag,
  output logic               o_busy,
  output logic               o_error,
  output logic               o_core_new_instance,
  output logic               o_core_pt_instance,
  output logic [BLOCK_W-1:0] o_core_cipher_key,
  output logic [IV_W-1:0]    o_core_iv,
  output logic [BLOCK_W-1:0] o_core_aad,
  output logic [BLOCK_W-1:0] o_core_plain_text,
  output logic [SIZE_W-1:0]  o_core_aad_size,
  output logic [SIZE_W-1:0]  o_core_plain_text_size,
  input  logic [BLOCK_W-1:0] i_core_cipher_text,
  input  logic [BLOCK_W-1:0] i_core_tag,
  input  logic               i_core_cp_ready,
  input  logic               i_core_tag_ready
);

  seq_state_t         r_state;
  logic [31:0]        r_wait_cnt;
  logic [CNT_W-1:0]   r_aad_cnt;
  logic [CNT_W-1:0]   r_pt_cnt;
  logic [BLOCK_W-1:0] r_key;
  logic [IV_W-1:0]    r_iv;
  logic [SIZE_W-1:0]  r_aad_size;
  logic [SIZE_W-1:0]  r_pt_size;
  logic [BLOCK_W-1:0] r_core_aad;
  logic [BLOCK_W-1:0] r_core_pt;
  logic               r_ct_valid;
  logic [BLOCK_W-1:0] r_ct_block;
  logic               r_tag_valid;
  logic [BLOCK_W-1:0] r_tag;
  logic               r_error;

  logic w_aad_acc;
  logic w_pt_acc;
  logic w_ct_acc;
  logic w_tag_acc;
  logic w_timeout;

  assign w_aad_acc = (r_state == S_AAD)      && i_aad_valid;
  assign w_pt_acc  = (r_state == S_PT_FEED)  && i_pt_valid;
  assign w_ct_acc  = (r_state == S_CT_WAIT)  && i_core_cp_ready;
  assign w_tag_acc = (r_state == S_TAG_WAIT) && i_core_tag_ready;

`ifdef GCM_SEQ_TIMEOUT_EN
  gcm_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_en      ((r_state == S_CT_WAIT) || (r_state == S_TAG_WAIT)),
    .i_restart (w_ct_acc || w_tag_acc),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign o_aad_ready            = (r_state == S_AAD);
  assign o_pt_ready             = (r_state == S_PT_FEED);
  assign o_busy                 = (r_state != S_IDLE);
  assign o_core_new_instance    = (r_state == S_INIT);
  // Plaintext and its strobe go to the core in the accept cycle itself, so the
  // strobe is never seen once the FSM has moved on to CT_WAIT; the block is then held.
  assign o_core_pt_instance     = w_pt_acc;
  assign o_core_plain_text      = w_pt_acc ? i_pt_block : r_core_pt;
  assign o_core_cipher_key      = r_key;
  assign o_core_iv              = r_iv;
  assign o_core_aad             = r_core_aad;
  assign o_core_aad_size        = r_aad_size;
  assign o_core_plain_text_size = r_pt_size;
  assign o_ct_valid             = r_ct_valid;
  assign o_ct_block             = r_ct_block;
  assign o_tag_valid            = r_tag_valid;
  assign o_tag                  = r_tag;
  assign o_error                = r_error;

  // message FSM with block counters and registered core-facing data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_aad_cnt   <= '0;
      r_pt_cnt    <= '0;
      r_key       <= '0;
      r_iv        <= '0;
      r_aad_size  <= '0;
      r_pt_size   <= '0;
      r_core_aad  <= '0;
      r_core_pt   <= '0;
      r_ct_valid  <= 1'b0;
      r_ct_block  <= '0;
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
      r_error     <= 1'b0;
    end else begin
      r_ct_valid  <= 1'b0;
      r_tag_valid <= 1'b0;
      r_error     <= 1'b0;
      if (w_timeout) begin
        r_state <= S_IDLE;
        r_error <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_key      <= i_cipher_key;
              r_iv       <= i_iv;
              r_aad_size <= i_aad_size;
              r_pt_size  <= i_plain_text_size;
              r_aad_cnt  <= blocks_of(i_aad_size);
              r_pt_cnt   <= blocks_of(i_plain_text_size);
              r_wait_cnt <= '0;
              r_state    <= S_INIT;
            end
          end
          S_INIT: begin
            if (r_wait_cnt == 32'(INIT_HOLD - 1)) begin
              r_wait_cnt <= '0;
              r_state    <= S_HWAIT;
            end else begin
              r_wait_cnt <= r_wait_cnt + 32'd1;
            end
          end
          S_HWAIT: begin
            if (r_wait_cnt == 32'(INIT_WAIT - 1)) begin
              r_wait_cnt <= '0;
              if (r_aad_cnt != '0)     r_state <= S_AAD;
              else if (r_pt_cnt != '0) r_state <= S_PT_FEED;
              else                     r_state <= S_TAG_WAIT;
            end else begin
              r_wait_cnt <= r_wait_cnt + 32'd1;
            end
          end
          S_AAD: begin
            if (w_aad_acc) begin
              r_core_aad <= i_aad_block;
              r_aad_cnt  <= r_aad_cnt - 1'b1;
              if (r_aad_cnt == CNT_W'(1)) begin
                r_state <= (r_pt_cnt != '0) ? S_PT_FEED : S_TAG_WAIT;
              end
            end
          end
          S_PT_FEED: begin
            if (w_pt_acc) begin
              r_core_pt <= i_pt_block;
              r_pt_cnt  <= r_pt_cnt - 1'b1;
              r_state   <= S_CT_WAIT;
            end
          end
          S_CT_WAIT: begin
            if (w_ct_acc) begin
              r_ct_block <= i_core_cipher_text;
              r_ct_valid <= 1'b1;
              r_state    <= (r_pt_cnt != '0) ? S_PT_FEED : S_TAG_WAIT;
            end
          end
          S_TAG_WAIT: begin
            if (w_tag_acc) begin
              r_tag       <= i_core_tag;
              r_tag_valid <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcm_aes_sequencer.sv
// Self-checking bench for gcm_aes_sequencer: the bench plays the gcm_aes core,
// drives table-driven messages and scoreboards ciphertext blocks and tags.
module tb_gcm_aes_sequencer;

  localparam int unsigned INIT_WAIT = 44;
  localparam int unsigned INIT_HOLD = 2;
  localparam int unsigned TIMEOUT   = 1024;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [127:0] i_cipher_key;
  logic [95:0]  i_iv;
  logic [63:0]  i_aad_size;
  logic [63:0]  i_plain_text_size;
  logic         i_aad_valid;
  logic         o_aad_ready;
  logic [127:0] i_aad_block;
  logic         i_pt_valid;
  logic         o_pt_ready;
  logic [127:0] i_pt_block;
  logic         o_ct_valid;
  logic [127:0] o_ct_block;
  logic         o_tag_valid;
  logic [127:0] o_tag;
  logic         o_busy;
  logic         o_error;
  logic         o_core_new_instance;
  logic         o_core_pt_instance;
  logic [127:0] o_core_cipher_key;
  logic [95:0]  o_core_iv;
  logic [127:0] o_core_aad;
  logic [127:0] o_core_plain_text;
  logic [63:0]  o_core_aad_size;
  logic [63:0]  o_core_plain_text_size;
  logic [127:0] i_core_cipher_text;
  logic [127:0] i_core_tag;
  logic         i_core_cp_ready;
  logic         i_core_tag_ready;

  gcm_aes_sequencer #(
    .INIT_WAIT(INIT_WAIT),
    .INIT_HOLD(INIT_HOLD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_cipher_key(i_cipher_key), .i_iv(i_iv),
    .i_aad_size(i_aad_size), .i_plain_text_size(i_plain_text_size),
    .i_aad_valid(i_aad_valid), .o_aad_ready(o_aad_ready), .i_aad_block(i_aad_block),
    .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_block(i_pt_block),
    .o_ct_valid(o_ct_valid), .o_ct_block(o_ct_block),
    .o_tag_valid(o_tag_valid), .o_tag(o_tag),
    .o_busy(o_busy), .o_error(o_error),
    .o_core_new_instance(o_core_new_instance), .o_core_pt_instance(o_core_pt_instance),
    .o_core_cipher_key(o_core_cipher_key), .o_core_iv(o_core_iv),
    .o_core_aad(o_core_aad), .o_core_plain_text(o_core_plain_text),
    .o_core_aad_size(o_core_aad_size), .o_core_plain_text_size(o_core_plain_text_size),
    .i_core_cipher_text(i_core_cipher_text), .i_core_tag(i_core_tag),
    .i_core_cp_ready(i_core_cp_ready), .i_core_tag_ready(i_core_tag_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [95:0]  iv;
    logic [63:0]  aad_bits;
    logic [63:0]  pt_bits;
    logic [127:0] pt_seed;
    logic [127:0] ks;
    logic [127:0] tag;
    int unsigned  lat;
    bit           gap;
    bit           perturb;
    bit           stray;
  } vec_t;

  vec_t vt[5];

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_ct_q[$];
  logic [127:0] exp_tag_q[$];
  int m_ct, m_tag, m_aad, m_pt, m_ni, m_err_tot;

  logic [127:0] core_ks;
  int unsigned  core_lat = 1;
  int unsigned  core_idx = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // output monitor: scoreboard pops and handshake counters
  initial begin
    m_ct = 0; m_tag = 0; m_aad = 0; m_pt = 0; m_ni = 0; m_err_tot = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_ct_valid) begin
          m_ct++;
          chk("ct_expected_pending", 128'(exp_ct_q.size() != 0), 128'd1);
          if (exp_ct_q.size() != 0) chk("ct_block", o_ct_block, exp_ct_q.pop_front());
        end
        if (o_tag_valid) begin
          m_tag++;
          chk("tag_after_all_ct", 128'(exp_ct_q.size()), 128'd0);
          chk("tag_expected_pending", 128'(exp_tag_q.size() != 0), 128'd1);
          if (exp_tag_q.size() != 0) chk("tag", o_tag, exp_tag_q.pop_front());
        end
        if (o_aad_ready && i_aad_valid) m_aad++;
        if (o_pt_ready && i_pt_valid)   m_pt++;
        if (o_core_new_instance)        m_ni++;
        if (o_core_pt_instance) chk("pt_instance_only_on_accept", {o_pt_ready, i_pt_valid}, 128'd3);
        if (o_error) m_err_tot++;
      end
    end
  end

  // gcm_aes core model: ciphertext = pt ^ keystream ^ block index, after core_lat cycles
  initial begin
    logic [127:0] p;
    i_core_cp_ready    = 1'b0;
    i_core_cipher_text = '0;
    forever begin
      @(negedge clk);
      if (o_core_pt_instance) begin
        p = o_core_plain_text;
        repeat (core_lat) @(posedge clk);
        #1;
        i_core_cipher_text = p ^ core_ks ^ 128'(core_idx);
        core_idx++;
        i_core_cp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_core_cp_ready = 1'b0;
      end
    end
  end

  task automatic run_msg(input vec_t v, input int unsigned id);
    longint unsigned n_aad, n_pt;
    int k, t;
    bit acc;
    logic [127:0] blk;
    n_aad = (longint'(v.aad_bits) + 127) / 128;
    n_pt  = (longint'(v.pt_bits) + 127) / 128;
    m_ct = 0; m_tag = 0; m_aad = 0; m_pt = 0; m_ni = 0;
    core_idx = 0; core_ks = v.ks; core_lat = v.lat;
    i_core_tag = v.tag; i_core_tag_ready = 1'b1;
    exp_tag_q.push_back(v.tag);
    @(posedge clk); #1;
    i_cipher_key = v.key; i_iv = v.iv;
    i_aad_size = v.aad_bits; i_plain_text_size = v.pt_bits;
    i_start = 1'b1;
    if (v.stray) begin i_aad_valid = 1'b1; i_pt_valid = 1'b1; end
    @(posedge clk); #1;
    i_start = 1'b0;
    // cycles from the start edge to the first AAD/PT ready (or tag when both are empty)
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(o_aad_ready || o_pt_ready || o_tag_valid) && k < 200);
    chk($sformatf("v%0d_first_phase_latency", id), 128'(k),
        128'(1 + INIT_HOLD + INIT_WAIT + ((n_aad == 0 && n_pt == 0) ? 1 : 0)));
    @(posedge clk); #1;
    for (int unsigned j = 0; j < n_aad; j++) begin
      blk = {v.iv, 32'(j) + 32'hA0A0_0000};
      i_aad_block = blk; i_aad_valid = 1'b1;
      acc = 1'b0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = o_aad_ready && i_aad_valid;
        @(posedge clk); #1;
        t++;
      end
      i_aad_valid = 1'b0;
      chk($sformatf("v%0d_aad%0d_accepted", id, j), 128'(acc), 128'd1);
      chk($sformatf("v%0d_core_aad%0d", id, j), o_core_aad, blk);
    end
    for (int unsigned i = 0; i < n_pt; i++) begin
      blk = v.pt_seed ^ {4{32'(i)}};
      exp_ct_q.push_back(blk ^ v.ks ^ 128'(i));
      i_pt_block = blk; i_pt_valid = 1'b1;
      if (v.perturb && i == 0) begin
        i_start = 1'b1; i_cipher_key = ~v.key; i_iv = ~v.iv;
      end
      acc = 1'b0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = o_pt_ready && i_pt_valid;
        @(posedge clk); #1;
        i_start = 1'b0; i_cipher_key = v.key; i_iv = v.iv;
        if (v.gap && !acc) i_pt_valid = ~i_pt_valid;
        t++;
      end
      i_pt_valid = 1'b0;
      chk($sformatf("v%0d_pt%0d_accepted", id, i), 128'(acc), 128'd1);
    end
    t = 0;
    while (m_tag == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    i_aad_valid = 1'b0; i_pt_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_tag_count", id), 128'(m_tag), 128'd1);
    chk($sformatf("v%0d_ct_count", id), 128'(m_ct), 128'(n_pt));
    chk($sformatf("v%0d_aad_accepts", id), 128'(m_aad), 128'(n_aad));
    chk($sformatf("v%0d_pt_accepts", id), 128'(m_pt), 128'(n_pt));
    chk($sformatf("v%0d_new_instance_cycles", id), 128'(m_ni), 128'(INIT_HOLD));
    chk($sformatf("v%0d_core_key", id), o_core_cipher_key, v.key);
    chk($sformatf("v%0d_core_iv", id), 128'(o_core_iv), 128'(v.iv));
    chk($sformatf("v%0d_core_sizes", id), {o_core_aad_size, o_core_plain_text_size},
        {v.aad_bits, v.pt_bits});
    chk($sformatf("v%0d_idle_after_tag", id), 128'(o_busy), 128'd0);
    exp_ct_q.delete();
    exp_tag_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    for (int unsigned i = 0; i < 5; i++) vt[i] = '{default: '0};
    vt[0].tag = 128'h58e2fccefa7e3061367f1d57a4e7455a; vt[0].lat = 1; vt[0].stray = 1'b1;
    vt[1].pt_bits = 64'd128; vt[1].lat = 2;
    vt[1].ks  = 128'h0388dace60b6a392f328c2b971b2fe78;
    vt[1].tag = 128'hab6e47d42cec13bdf53a67b21257bddf;
    vt[2].key = 128'hfeffe9928665731c6d6a8f9467308308; vt[2].iv = 96'hcafebabefacedbaddecaf888;
    vt[2].aad_bits = 64'd128; vt[2].pt_bits = 64'd512; vt[2].lat = 3; vt[2].gap = 1'b1;
    vt[2].pt_seed = 128'hd9313225f88406e5a55909c5aff5269a;
    vt[2].ks  = 128'h42831ec2217774244b7221b784d0d49c;
    vt[2].tag = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
    vt[3].key = 128'h00112233445566778899aabbccddeeff; vt[3].iv = 96'h0123456789abcdef01234567;
    vt[3].aad_bits = 64'd200; vt[3].pt_bits = 64'd129; vt[3].lat = 1; vt[3].perturb = 1'b1;
    vt[3].pt_seed = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    vt[3].ks  = 128'h0f0e0d0c0b0a09080706050403020100;
    vt[3].tag = 128'hdeadbeef00000000cafef00d12345678;
    vt[4].key = 128'h1; vt[4].iv = 96'h2; vt[4].aad_bits = 64'd256; vt[4].lat = 1;
    vt[4].tag = 128'h0123456789abcdeffedcba9876543210;

    rst = 1'b1; i_start = 1'b0; i_cipher_key = '0; i_iv = '0;
    i_aad_size = '0; i_plain_text_size = '0;
    i_aad_valid = 1'b0; i_aad_block = '0; i_pt_valid = 1'b0; i_pt_block = '0;
    i_core_tag = '0; i_core_tag_ready = 1'b0; core_ks = '0;
    @(negedge clk);
    chk("reset_flags", {o_busy, o_aad_ready, o_pt_ready, o_ct_valid, o_tag_valid, o_error,
                        o_core_new_instance, o_core_pt_instance}, 128'd0);
    chk("reset_core_key", o_core_cipher_key, 128'd0);
    chk("reset_tag", o_tag, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int unsigned i = 0; i < 5; i++) run_msg(vt[i], i);

    // reset asserted while waiting for the core's ciphertext
    core_idx = 0; core_lat = 6; core_ks = 128'h1;
    @(posedge clk); #1;
    i_cipher_key = 128'hfeedface; i_iv = 96'h77; i_aad_size = '0;
    i_plain_text_size = 64'd256; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    t = 0;
    while (!o_pt_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_reached_pt_feed", 128'(o_pt_ready), 128'd1);
    @(posedge clk); #1;
    i_pt_valid = 1'b1; i_pt_block = 128'h99;
    @(posedge clk); #1;
    i_pt_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midmsg_rst_flags", {o_busy, o_aad_ready, o_pt_ready, o_ct_valid, o_tag_valid, o_error,
                             o_core_new_instance, o_core_pt_instance}, 128'd0);
    chk("midmsg_rst_core_key", o_core_cipher_key, 128'd0);
    chk("midmsg_rst_core_pt", o_core_plain_text, 128'd0);
    chk("midmsg_rst_sizes", {o_core_aad_size, o_core_plain_text_size}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ct = 0; m_tag = 0;
    repeat (12) @(negedge clk);
    chk("no_pulse_after_rst_release", 128'({m_ct[15:0], m_tag[15:0]}), 128'd0);
    chk("idle_after_rst_release", 128'(o_busy), 128'd0);
    run_msg(vt[1], 5);

`ifdef GCM_SEQ_TIMEOUT_EN
    // tag never arrives: watchdog fires TIMEOUT cycles into TAG_WAIT
    i_core_tag_ready = 1'b0;
    @(posedge clk); #1;
    i_aad_size = '0; i_plain_text_size = '0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_error && t < 3000);
    chk("timeout_latency", 128'(t), 128'(1 + INIT_HOLD + INIT_WAIT + TIMEOUT));
    chk("timeout_idle", 128'(o_busy), 128'd0);
    @(negedge clk);
    chk("timeout_single_pulse", 128'(o_error), 128'd0);
`else
    chk("no_error_pulses", 128'(m_err_tot), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
